mipi_rffe_master: RTL and testbench

- Serial engine behind the packet decoder's MIPI port. It turns one decoded register-access command into a single RFFE register write or register read frame.
- It drives sclk, sdo and sdo_en, and samples sdi. The top level steers these onto the selected SCLK/SDA bank.
- It runs on the 52 MHz MIPI clock and returns read data plus a parity status to the decoder.

---
 rtl/mipi_rffe_master.sv | 196 +++++++++++++++++++
 tb/tb_mipi_rffe_master.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_rffe_master.sv
// rtl/mipi_rffe_master.sv - RFFE register write/read frame engine
// Purpose: turns one captured register-access command into a single RFFE
//          frame (SSC, command, write data or bus-park + read data, bus park).
//          All pin outputs come from registers, so sclk is glitch-free.
// Ports:
//   clk, rst_n                    engine clock, async active-low reset
//   cmd_vd/rd/sa/addr/wdata       command strobe and fields (taken while idle)
//   busy, done                    frame in progress / one-cycle end pulse
//   rd_data, parity_err           last read byte and its parity status
//   sclk, sdo, sdo_en, sdi        RFFE bus pins
module mipi_rffe_master #(
  parameter int HALF_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_vd,
  input  logic       cmd_rd,
  input  logic [3:0] cmd_sa,
  input  logic [4:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       parity_err,
  output logic       sclk,
  output logic       sdo,
  output logic       sdo_en,
  input  logic       sdi
);
  localparam int SLOT_LEN = 2 * HALF_DIV;
  localparam int SLOT_W   = $clog2(SLOT_LEN);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_LEN - 1);
  localparam logic [SLOT_W-1:0] HIGH_LAST = SLOT_W'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SSC_H, S_SSC_L, S_CMD, S_WDATA, S_BP_RD, S_RDATA, S_BP_END
  } state_t;

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [3:0]        bit_q, bit_d;
  logic              rd_q;
  logic [3:0]        sa_q;
  logic [4:0]        addr_q;
  logic [7:0]        wdata_q;
  logic [7:0]        shift_q;
  logic              rpar_q;
  logic              busy_q, done_q, perr_q, sclk_q, sdo_q, sdo_en_q;
  logic [7:0]        rd_data_q;
  logic              sclk_d, sdo_d, sdo_en_d;
  logic              accept, slot_end, state_end, frame_end, high_d;
  logic [3:0]        last_bit;
  logic [12:0]       cmd_word;
  logic [8:0]        wd_word;

  // Command type field is 3'b010 (write) / 3'b011 (read); odd parity on each word.
  assign cmd_word = {sa_q, 2'b01, rd_q, addr_q, ~^{sa_q, 2'b01, rd_q, addr_q}};
  assign wd_word  = {wdata_q, ~^wdata_q};

  always_comb begin
    case (state_q)
      S_CMD:            last_bit = 4'd12;
      S_WDATA, S_RDATA: last_bit = 4'd8;
      default:          last_bit = 4'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    bit_d     = bit_q;
    accept    = 1'b0;
    frame_end = 1'b0;
    slot_end  = (slot_q == SLOT_LAST);
    state_end = slot_end && (bit_q == last_bit);
    if (state_q == S_IDLE) begin
      if (cmd_vd) begin
        accept  = 1'b1;
        state_d = S_SSC_H;
        slot_d  = '0;
        bit_d   = '0;
      end
    end else begin
      slot_d = slot_end ? '0 : slot_q + SLOT_W'(1);
      if (state_end) begin
        bit_d = '0;
        case (state_q)
          S_SSC_H: state_d = S_SSC_L;
          S_SSC_L: state_d = S_CMD;
          S_CMD:   state_d = rd_q ? S_BP_RD : S_WDATA;
          S_WDATA: state_d = S_BP_END;
          S_BP_RD: state_d = S_RDATA;
          S_RDATA: state_d = S_BP_END;
          S_BP_END: begin
            state_d   = S_IDLE;
            frame_end = 1'b1;
          end
          default: state_d = S_IDLE;
        endcase
      end else if (slot_end) begin
        bit_d = bit_q + 4'd1;
      end
    end
  end

  // Pin values are derived from the next state/counters and registered,
  // so they line up with the state they belong to.
  always_comb begin
    high_d   = (slot_d <= HIGH_LAST);
    sclk_d   = 1'b0;
    sdo_d    = 1'b0;
    sdo_en_d = 1'b0;
    case (state_d)
      S_SSC_H: begin
        sdo_d    = 1'b1;
        sdo_en_d = 1'b1;
      end
      S_SSC_L: sdo_en_d = 1'b1;
      S_CMD: begin
        sclk_d   = high_d;
        sdo_d    = cmd_word[4'd12 - bit_d];
        sdo_en_d = 1'b1;
      end
      S_WDATA: begin
        sclk_d   = high_d;
        sdo_d    = wd_word[4'd8 - bit_d];
        sdo_en_d = 1'b1;
      end
      // Park: drive 0 while sclk is high, then release for the slave.
      S_BP_RD: begin
        sclk_d   = high_d;
        sdo_en_d = high_d;
      end
      S_RDATA: sclk_d = high_d;
      S_BP_END: begin
        sclk_d   = high_d;
        sdo_en_d = high_d & ~rd_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      slot_q    <= '0;
      bit_q     <= '0;
      rd_q      <= 1'b0;
      sa_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      shift_q   <= '0;
      rpar_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      perr_q    <= 1'b0;
      rd_data_q <= '0;
      sclk_q    <= 1'b0;
      sdo_q     <= 1'b0;
      sdo_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      bit_q    <= bit_d;
      busy_q   <= (state_d != S_IDLE);
      done_q   <= frame_end;
      sclk_q   <= sclk_d;
      sdo_q    <= sdo_d;
      sdo_en_q <= sdo_en_d;
      if (accept) begin
        rd_q    <= cmd_rd;
        sa_q    <= cmd_sa;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        perr_q  <= 1'b0;
      end
      // Sample on the last high cycle, i.e. at the sclk falling edge.
      if (state_q == S_RDATA && slot_q == HIGH_LAST) begin
        if (bit_q == 4'd8) rpar_q <= sdi;
        else               shift_q <= {shift_q[6:0], sdi};
      end
      if (frame_end && rd_q) begin
        rd_data_q <= shift_q;
        perr_q    <= ~^{shift_q, rpar_q};
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_data    = rd_data_q;
  assign parity_err = perr_q;
  assign sclk       = sclk_q;
  assign sdo        = sdo_q;
  assign sdo_en     = sdo_en_q;
endmodule

// File: tb/tb_mipi_rffe_master.sv
// tb/tb_mipi_rffe_master.sv - scoreboard bench for mipi_rffe_master
module tb_mipi_rffe_master;
  logic       clk;
  logic       rst_n;
  logic       cmd_vd_a [2];
  logic       cmd_rd;
  logic [3:0] cmd_sa;
  logic [4:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       busy_a [2];
  logic       done_a [2];
  logic [7:0] rdd_a [2];
  logic       perr_a [2];
  logic       sclk_a [2];
  logic       sdo_a [2];
  logic       sdo_en_a [2];
  logic       sdi_a [2];

  typedef struct {
    int          inst;
    logic        rd;
    int          nbits;
    logic [22:0] bits;
    int          busy_cyc;
    logic [8:0]  slave9;
    logic [7:0]  rdata;
    logic        perr;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_push = 0;
  int          done_cnt = 0;
  int          rise_cnt [2];
  int          got_n [2];
  int          busy_cyc [2];
  logic [22:0] got_bits [2];
  logic        prev_sclk [2];
  logic        en_viol [2];
  int          sidx;

  mipi_rffe_master #(.HALF_DIV(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_vd(cmd_vd_a[0]), .cmd_rd(cmd_rd), .cmd_sa(cmd_sa),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .busy(busy_a[0]), .done(done_a[0]),
    .rd_data(rdd_a[0]), .parity_err(perr_a[0]), .sclk(sclk_a[0]), .sdo(sdo_a[0]),
    .sdo_en(sdo_en_a[0]), .sdi(sdi_a[0])
  );

  mipi_rffe_master #(.HALF_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_vd(cmd_vd_a[1]), .cmd_rd(cmd_rd), .cmd_sa(cmd_sa),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .busy(busy_a[1]), .done(done_a[1]),
    .rd_data(rdd_a[1]), .parity_err(perr_a[1]), .sclk(sclk_a[1]), .sdo(sdo_a[1]),
    .sdo_en(sdo_en_a[1]), .sdi(sdi_a[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input int inst, input logic rd, input int nbits, input logic [22:0] bits,
                          input int bc, input logic [8:0] slave9, input logic [7:0] rdata,
                          input logic perr);
    exp_t x;
    x.inst = inst; x.rd = rd; x.nbits = nbits; x.bits = bits; x.busy_cyc = bc;
    x.slave9 = slave9; x.rdata = rdata; x.perr = perr;
    sbq.push_back(x);
    n_push++;
  endtask

  task automatic issue(input int inst, input logic rd, input logic [3:0] sa,
                       input logic [4:0] a, input logic [7:0] wd);
    @(negedge clk);
    cmd_rd = rd; cmd_sa = sa; cmd_addr = a; cmd_wdata = wd;
    cmd_vd_a[inst] = 1'b1;
    @(negedge clk);
    cmd_vd_a[inst] = 1'b0;
  endtask

  task automatic wait_idle(input int inst);
    int n = 0;
    while (busy_a[inst] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy_a[inst], 0);
  endtask

  // Bus monitor + slave model + scoreboard checker for both instances.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (done_a[i]) begin
        done_cnt++;
        if (sbq.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("inst", i, e.inst);
          check("nbits", got_n[i], e.nbits);
          check("bits", got_bits[i], e.bits);
          check("busy_cycles", busy_cyc[i], e.busy_cyc);
          check("rd_data", rdd_a[i], e.rdata);
          check("parity_err", perr_a[i], e.perr);
          check("sdo_en_in_rdata", en_viol[i], 0);
          check("pins_after_frame", {sclk_a[i], sdo_a[i], sdo_en_a[i]}, 0);
        end
      end
      if (!busy_a[i]) begin
        rise_cnt[i] = 0; got_n[i] = 0; got_bits[i] = '0; busy_cyc[i] = 0;
        en_viol[i] = 1'b0; prev_sclk[i] = 1'b0; sdi_a[i] = 1'b0;
      end else begin
        busy_cyc[i]++;
        if (sclk_a[i] && !prev_sclk[i]) begin
          rise_cnt[i]++;
          if (sdo_en_a[i]) begin
            got_bits[i] = {got_bits[i][21:0], sdo_a[i]};
            got_n[i]++;
          end
          if (sbq.size() > 0 && sbq[0].rd && rise_cnt[i] >= 15 && rise_cnt[i] <= 23) begin
            sidx = 23 - rise_cnt[i];
            sdi_a[i] = sbq[0].slave9[sidx];
          end
        end
        if (sbq.size() > 0 && sbq[0].rd && rise_cnt[i] >= 15 && sdo_en_a[i]) en_viol[i] = 1'b1;
        prev_sclk[i] = sclk_a[i];
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    cmd_vd_a[0] = 1'b0; cmd_vd_a[1] = 1'b0;
    cmd_rd = 1'b0; cmd_sa = '0; cmd_addr = '0; cmd_wdata = '0;
    #12;
    check("rst_busy", busy_a[0], 0);
    check("rst_done", done_a[0], 0);
    check("rst_rd_data", rdd_a[0], 0);
    check("rst_parity_err", perr_a[0], 0);
    check("rst_pins", {sclk_a[0], sdo_a[0], sdo_en_a[0]}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Write SA=7 addr=0x1C data=0xA5
    push_exp(0, 1'b0, 23, {13'b0111_010_11100_0, 9'b1010_0101_1, 1'b0}, 100, 9'h0, 8'h00, 1'b0);
    issue(0, 1'b0, 4'h7, 5'h1C, 8'hA5);
    check("busy_after_accept", busy_a[0], 1);
    wait_idle(0);

    // Read SA=3 addr=0x05, slave 0x3C with good parity
    push_exp(0, 1'b1, 14, {9'b0, 13'b0011_011_00101_1, 1'b0}, 104, {8'h3C, 1'b1}, 8'h3C, 1'b0);
    issue(0, 1'b1, 4'h3, 5'h05, 8'h00);
    wait_idle(0);

    // Same read, slave parity wrong
    push_exp(0, 1'b1, 14, {9'b0, 13'b0011_011_00101_1, 1'b0}, 104, {8'h3C, 1'b0}, 8'h3C, 1'b1);
    issue(0, 1'b1, 4'h3, 5'h05, 8'h00);
    wait_idle(0);

    // Write clears parity_err on acceptance, rd_data held
    push_exp(0, 1'b0, 23, {13'b0010_010_00011_1, 9'b0000_0000_1, 1'b0}, 100, 9'h0, 8'h3C, 1'b0);
    issue(0, 1'b0, 4'h2, 5'h03, 8'h00);
    check("perr_clear_on_accept", perr_a[0], 0);
    check("rd_data_held", rdd_a[0], 8'h3C);
    wait_idle(0);

    // Write with an ignored cmd_vd at cycle 10, then back-to-back write in done cycle
    push_exp(0, 1'b0, 23, {13'b1111_010_11111_1, 9'b1111_1111_1, 1'b0}, 100, 9'h0, 8'h3C, 1'b0);
    issue(0, 1'b0, 4'hF, 5'h1F, 8'hFF);
    repeat (9) @(negedge clk);
    cmd_rd = 1'b1; cmd_sa = 4'h1; cmd_addr = 5'h02; cmd_wdata = 8'h00;
    cmd_vd_a[0] = 1'b1;
    @(negedge clk);
    cmd_vd_a[0] = 1'b0;
    n = 0;
    while (!done_a[0] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done_seen", done_a[0], 1);
    push_exp(0, 1'b0, 23, {13'b0001_010_01010_1, 9'b0011_1100_1, 1'b0}, 100, 9'h0, 8'h3C, 1'b0);
    cmd_rd = 1'b0; cmd_sa = 4'h1; cmd_addr = 5'h0A; cmd_wdata = 8'h3C;
    cmd_vd_a[0] = 1'b1;
    @(negedge clk);
    cmd_vd_a[0] = 1'b0;
    check("b2b_busy", busy_a[0], 1);
    check("b2b_ssc_h_pins", {sclk_a[0], sdo_a[0], sdo_en_a[0]}, 3'b011);
    wait_idle(0);

    // Reset during CMD bit 6: abort with no done
    issue(0, 1'b0, 4'h5, 5'h11, 8'h55);
    repeat (33) @(negedge clk);
    check("abort_busy_before", busy_a[0], 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy_a[0], 0);
    check("abort_done", done_a[0], 0);
    check("abort_rd_data", rdd_a[0], 0);
    check("abort_pins", {sclk_a[0], sdo_a[0], sdo_en_a[0]}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    push_exp(0, 1'b0, 23, {13'b0111_010_11100_0, 9'b1010_0101_1, 1'b0}, 100, 9'h0, 8'h00, 1'b0);
    issue(0, 1'b0, 4'h7, 5'h1C, 8'hA5);
    wait_idle(0);

    // HALF_DIV=1 instance, same write
    push_exp(1, 1'b0, 23, {13'b0111_010_11100_0, 9'b1010_0101_1, 1'b0}, 50, 9'h0, 8'h00, 1'b0);
    issue(1, 1'b0, 4'h7, 5'h1C, 8'hA5);
    wait_idle(1);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    check("done_count", done_cnt, n_push);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
